// File: rtl/grid_scan_tx_if.sv
// Column/row drive bundle between the grid source, grid_scan_tx and the LED matrix.
// The master modport drives the grid and the scan enable; the slave modport drives the LED lines.
interface grid_scan_tx_if;
    logic [15:0] grid;
    logic        en;
    logic        ser_clk;
    logic        ser_data;
    logic        ser_latch;
    logic [1:0]  row_en;
    logic        busy;
    logic        frame_done;

    modport master (
        output grid,
        output en,
        input  ser_clk,
        input  ser_data,
        input  ser_latch,
        input  row_en,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  grid,
        input  en,
        output ser_clk,
        output ser_data,
        output ser_latch,
        output row_en,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/grid_scan_tx.sv
// Two-row scanner for the 2x8 play field. Each row is shifted out serially, latched, then lit for DWELL cycles.
// Define GRID_SCAN_ACTIVE_LOW_EN for a common-anode matrix: this inverts row_en and the shifted cell bits.
module grid_scan_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DWELL   = 16
) (
    input  logic          clk,
    input  logic          reset,
    grid_scan_tx_if.slave bus
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam int unsigned DW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DW_LAST  = DW'(DWELL - 1);

`ifdef GRID_SCAN_ACTIVE_LOW_EN
    localparam logic [1:0] ROW_BLANK = 2'b11;
    localparam logic [1:0] ROW0_ON   = 2'b10;
    localparam logic [1:0] ROW1_ON   = 2'b01;
    localparam logic       DATA_INV  = 1'b1;
`else
    localparam logic [1:0] ROW_BLANK = 2'b00;
    localparam logic [1:0] ROW0_ON   = 2'b01;
    localparam logic [1:0] ROW1_ON   = 2'b10;
    localparam logic       DATA_INV  = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DWELL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d;
    logic [2:0]    bit_q, bit_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          row_q, row_d;
    logic [15:0]   snap_q, snap_d;
    logic [7:0]    sh_q, sh_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            dcnt_q  <= '0;
            row_q   <= 1'b0;
            snap_q  <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            dcnt_q  <= dcnt_d;
            row_q   <= row_d;
            snap_q  <= snap_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        bit_d   = bit_q;
        dcnt_d  = dcnt_q;
        row_d   = row_q;
        snap_d  = snap_q;
        sh_d    = sh_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                half_d = 1'b0;
                bit_d  = '0;
                dcnt_d = '0;
                row_d  = 1'b0;
                if (bus.en) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // Row 0 reads the live grid on the same edge the snapshot is taken, so both rows share one frame image.
                if (!row_q) begin
                    snap_d = bus.grid;
                    sh_d   = bus.grid[7:0];
                end else begin
                    sh_d   = snap_q[15:8];
                end
                cnt_d   = '0;
                half_d  = 1'b0;
                bit_d   = '0;
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        sh_d   = {sh_q[6:0], 1'b0};
                        if (bit_q == 3'd7) begin
                            bit_d   = '0;
                            state_d = S_LATCH;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_LATCH: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    state_d = S_DWELL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DWELL: begin
                if (dcnt_q == DW_LAST) begin
                    dcnt_d = '0;
                    if (!row_q) begin
                        row_d   = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        row_d   = 1'b0;
                        state_d = bus.en ? S_LOAD : S_IDLE;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.ser_clk    = 1'b0;
        bus.ser_data   = 1'b0;
        bus.ser_latch  = 1'b0;
        bus.row_en     = ROW_BLANK;
        bus.busy       = (state_q != S_IDLE);
        bus.frame_done = 1'b0;

        unique case (state_q)
            S_SHIFT: begin
                bus.ser_clk  = half_q;
                bus.ser_data = sh_q[7] ^ DATA_INV;
            end
            S_LATCH: begin
                bus.ser_latch = 1'b1;
            end
            S_DWELL: begin
                bus.row_en     = row_q ? ROW1_ON : ROW0_ON;
                bus.frame_done = row_q && (dcnt_q == DW_LAST);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_grid_scan_tx.sv
// Directed bench for grid_scan_tx: default timing instance plus a CLK_DIV=1/DWELL=1 instance.
module tb_grid_scan_tx;

`ifdef GRID_SCAN_ACTIVE_LOW_EN
    localparam logic [1:0] BLANK = 2'b11;
    localparam logic [1:0] ON0   = 2'b10;
    localparam logic [1:0] ON1   = 2'b01;
    localparam logic [7:0] INV   = 8'hFF;
`else
    localparam logic [1:0] BLANK = 2'b00;
    localparam logic [1:0] ON0   = 2'b01;
    localparam logic [1:0] ON1   = 2'b10;
    localparam logic [7:0] INV   = 8'h00;
`endif

    logic clk;
    logic rst;
    logic rst_f;
    logic sel_f;

    grid_scan_tx_if bus ();
    grid_scan_tx_if bf ();

    grid_scan_tx u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    grid_scan_tx #(
        .CLK_DIV (1),
        .DWELL   (1)
    ) u_fast (
        .clk   (clk),
        .reset (rst_f),
        .bus   (bf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       p_clk, p_data, p_latch, p_busy, p_fd;
    logic [1:0] p_row;

    always_comb begin
        if (sel_f) begin
            p_clk = bf.ser_clk;   p_data = bf.ser_data;  p_latch = bf.ser_latch;
            p_busy = bf.busy;     p_fd = bf.frame_done;  p_row = bf.row_en;
        end else begin
            p_clk = bus.ser_clk;  p_data = bus.ser_data; p_latch = bus.ser_latch;
            p_busy = bus.busy;    p_fd = bus.frame_done; p_row = bus.row_en;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int fd_last = 0;
    int fd_prev = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (p_fd) begin
            fd_prev = fd_last;
            fd_last = cyc;
        end
    endtask

    task automatic hook(input int t, input int ht, input logic [15:0] hg, input logic he);
        if (t == ht) begin
            bus.grid = hg;
            bus.en   = he;
        end
    endtask

    // Entered with the DUT sampled in LOAD; leaves one cycle into the following state.
    task automatic run_row(input string tag, input logic [7:0] exp_bits, input logic row,
                           input int ht, input logic [15:0] hg, input logic he);
        int cd, dw, t, e_shape, e_rowen, e_latch, e_dwell;
        logic [7:0] got;
        logic prev_d;
        cd = sel_f ? 1 : 2;
        dw = sel_f ? 1 : 16;
        t = 0; e_shape = 0; e_rowen = 0; e_latch = 0; e_dwell = 0;
        got = '0; prev_d = 1'b0;
        check({tag, "_load"}, {p_busy, p_row, p_clk, p_latch, p_data, p_fd}, {1'b1, BLANK, 4'b0000});
        for (int i = 0; i < 16 * cd; i++) begin
            int b, p;
            tick(); t++;
            b = i / (2 * cd);
            p = i % (2 * cd);
            if (p_clk !== (p >= cd)) e_shape++;
            if (p > 0 && p_data !== prev_d) e_shape++;
            if (p == cd) got[7 - b] = p_data;
            prev_d = p_data;
            if (p_row !== BLANK || p_latch !== 1'b0 || p_busy !== 1'b1 || p_fd !== 1'b0) e_rowen++;
            hook(t, ht, hg, he);
        end
        check({tag, "_bits"}, got, exp_bits ^ INV);
        for (int i = 0; i < cd; i++) begin
            tick(); t++;
            if (p_latch !== 1'b1 || p_clk !== 1'b0 || p_data !== 1'b0 || p_row !== BLANK || p_fd !== 1'b0) e_latch++;
            hook(t, ht, hg, he);
        end
        for (int i = 0; i < dw; i++) begin
            tick(); t++;
            if (p_row !== (row ? ON1 : ON0) || p_latch !== 1'b0 || p_clk !== 1'b0 || p_data !== 1'b0) e_dwell++;
            if (p_fd !== (row && i == dw - 1)) e_dwell++;
            hook(t, ht, hg, he);
        end
        tick();
        check({tag, "_shape"}, e_shape, 0);
        check({tag, "_blank"}, e_rowen, 0);
        check({tag, "_latch"}, e_latch, 0);
        check({tag, "_dwell"}, e_dwell, 0);
    endtask

    task automatic check_idle(input string tag);
        check(tag, {p_busy, p_row, p_clk, p_latch, p_data, p_fd}, {1'b0, BLANK, 4'b0000});
    endtask

    initial begin
        sel_f = 1'b0;
        rst = 1'b1;
        rst_f = 1'b1;
        bus.grid = 16'h0080;
        bus.en = 1'b0;
        bf.grid = 16'h3CA5;
        bf.en = 1'b0;
        tick(); tick();
        check_idle("reset");
        rst = 1'b0;
        tick(); tick();
        check_idle("idle_en0");

        // Frame 1: dino down.
        bus.en = 1'b1;
        tick();
        run_row("f1r0", 8'h80, 1'b0, -1, 16'h0, 1'b0);
        run_row("f1r1", 8'h00, 1'b1, -1, 16'h0, 1'b0);

        // Frame 2: grid changes mid row0 shift; snapshot must hide it.
        run_row("f2r0", 8'h80, 1'b0, 5, 16'h8000, 1'b1);
        run_row("f2r1", 8'h00, 1'b1, -1, 16'h0, 1'b0);
        check("frame_period", fd_last - fd_prev, 102);

        // Frame 3: jump pattern; en dropped during row0 dwell.
        run_row("f3r0", 8'h00, 1'b0, 40, 16'h8000, 1'b0);
        run_row("f3r1", 8'h80, 1'b1, -1, 16'h0, 1'b0);
        check("frame_period2", fd_last - fd_prev, 102);
        check_idle("idle_after");
        tick(); tick(); tick();
        check_idle("idle_hold");

        // Reset during the 5th shifted bit.
        bus.grid = 16'h0080;
        bus.en = 1'b1;
        tick();
        for (int i = 0; i < 18; i++) tick();
        check("mid_shift_busy", p_busy, 1'b1);
        rst = 1'b1;
        tick();
        check_idle("mid_reset");
        bus.grid = 16'h8000;
        rst = 1'b0;
        tick();
        run_row("rsr0", 8'h00, 1'b0, -1, 16'h0, 1'b0);
        bus.en = 1'b0;
        run_row("rsr1", 8'h80, 1'b1, -1, 16'h0, 1'b0);
        check_idle("rs_idle");

        // Fast instance: CLK_DIV=1, DWELL=1.
        sel_f = 1'b1;
        rst_f = 1'b0;
        tick();
        check_idle("fast_reset");
        bf.en = 1'b1;
        tick();
        run_row("fr0a", 8'hA5, 1'b0, -1, 16'h0, 1'b0);
        run_row("fr1a", 8'h3C, 1'b1, -1, 16'h0, 1'b0);
        run_row("fr0b", 8'hA5, 1'b0, -1, 16'h0, 1'b0);
        bf.en = 1'b0;
        run_row("fr1b", 8'h3C, 1'b1, -1, 16'h0, 1'b0);
        check("fast_period", fd_last - fd_prev, 38);
        check_idle("fast_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
